// File: rtl/barrett_modmul_pipe_if.sv
// rtl/barrett_modmul_pipe_if.sv - operand, result and reconfiguration bus of the Barrett modular multiplier
interface barrett_modmul_pipe_if #(
  parameter int W     = 64,
  parameter int TAG_W = 8
);
  // Operand stream into the multiplier
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [TAG_W-1:0] in_tag;

  // Result stream, single-cycle qualifier, no backpressure
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  // Modulus reload request and status
  logic             cfg_req;
  logic [W-1:0]     cfg_q;
  logic [W:0]       cfg_mu;
  logic             cfg_busy;
  logic             cfg_done;

  modport master (
    output in_valid, in_a, in_b, in_tag, cfg_req, cfg_q, cfg_mu,
    input  in_ready, out_valid, out_data, out_tag, out_err, cfg_busy, cfg_done
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, cfg_req, cfg_q, cfg_mu,
    output in_ready, out_valid, out_data, out_tag, out_err, cfg_busy, cfg_done
  );
endinterface

// File: rtl/barrett_modmul_pipe.sv
// rtl/barrett_modmul_pipe.sv - pipelined Barrett (a*b) mod q with drain-then-load modulus reload; MODMUL_RANGE_CHECK_EN adds operand range flagging
module barrett_modmul_pipe #(
  parameter int           W          = 64,
  parameter int           MUL_STAGES = 2,
  parameter int           TAG_W      = 8,
  parameter logic [W-1:0] Q_DEFAULT  = 64'd18434813901432784897,
  parameter logic [W:0]   MU_DEFAULT = 65'd18458681966650671896
) (
  input logic                  clk,
  input logic                  rst,
  barrett_modmul_pipe_if.slave bus
);

  localparam int MS    = MUL_STAGES;
  localparam int LAT   = 3 * MS + 3;
  localparam int OCC_W = $clog2(LAT + 1);
  localparam int W1    = W + 1;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_LOAD
  } state_t;

  state_t       state;
  logic         in_ready_r;
  logic         cfg_busy_r;
  logic         cfg_done_r;
  logic [W-1:0] q_reg;
  logic [W:0]   mu_reg;
  logic [W-1:0] shadow_q;
  logic [W:0]   shadow_mu;

  logic             accept;
  logic             err_in;
  logic [OCC_W-1:0] occ;
  logic             drain_done;

  // Sideband pipeline: index 0 is the input register, index LAT-1 the output register
  logic [LAT-1:0]   v_pipe;
  logic [LAT-1:0]   err_pipe;
  logic [TAG_W-1:0] tag_pipe [LAT];

  // Datapath registers
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [2*W-1:0] m1 [MS];
  logic [W:0]     m2 [MS];
  logic [W:0]     d2 [MS];
  logic [W:0]     m3 [MS];
  logic [W:0]     d3 [MS];
  logic [W-1:0]   corr_r;
  logic [W-1:0]   res_r;

  // Combinational stage results
  logic [2*W-1:0] prod1;
  logic [3*W:0]   prod2;
  logic [W:0]     s_d;
  logic [W:0]     r_d;
  logic [W:0]     u_d;
  logic [W:0]     q_ext;
  logic [W-1:0]   corr_d;

  assign accept = bus.in_valid && in_ready_r;

`ifdef MODMUL_RANGE_CHECK_EN
  assign err_in = (bus.in_a >= q_reg) || (bus.in_b >= q_reg);
`else
  assign err_in = 1'b0;
`endif

  // D = a*b at full 2W width
  assign prod1 = {{W{1'b0}}, a_r} * {{W{1'b0}}, b_r};
  // Quotient estimate s = (D*mu) >> 2W, which fits in W+1 bits
  assign prod2 = {{W1{1'b0}}, m1[MS-1]} * {{(2*W){1'b0}}, mu_reg};
  assign s_d   = W1'(prod2 >> (2 * W));
  // Only the low W+1 bits of s*q matter because the remainder is below 2q
  assign q_ext = {1'b0, q_reg};
  assign r_d   = m2[MS-1] * q_ext;
  assign u_d   = d3[MS-1] - m3[MS-1];
  // s undershoots the true quotient by at most one, so a single subtraction finishes the reduction
  assign corr_d = W'((u_d >= q_ext) ? (u_d - q_ext) : u_d);

  assign drain_done = (occ == OCC_W'(v_pipe[LAT-1]));

  // Operand capture and the three multiply pipelines; the q/mu registers stay frozen while anything is in flight
  always_ff @(posedge clk) begin
    a_r <= bus.in_a;
    b_r <= bus.in_b;
    m1[0] <= prod1;
    m2[0] <= s_d;
    d2[0] <= m1[MS-1][W:0];
    m3[0] <= r_d;
    d3[0] <= d2[MS-1];
    for (int i = 1; i < MS; i++) begin
      m1[i] <= m1[i-1];
      m2[i] <= m2[i-1];
      d2[i] <= d2[i-1];
      m3[i] <= m3[i-1];
      d3[i] <= d3[i-1];
    end
    corr_r <= corr_d;
  end

  // Valid, tag and error flags march alongside the data; the output register zeroes errored results
  always_ff @(posedge clk) begin
    if (rst) begin
      v_pipe   <= '0;
      err_pipe <= '0;
      res_r    <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      v_pipe      <= {v_pipe[LAT-2:0], accept};
      err_pipe    <= {err_pipe[LAT-2:0], err_in};
      tag_pipe[0] <= bus.in_tag;
      for (int i = 1; i < LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
      res_r <= err_pipe[LAT-2] ? '0 : corr_r;
    end
  end

  // Occupancy tracks ops between acceptance and their out_valid cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
    end else begin
      occ <= occ + OCC_W'(accept) - OCC_W'(v_pipe[LAT-1]);
    end
  end

  // Reconfiguration FSM: stop accepting, wait for the pipe to empty, swap q/mu, resume
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RUN;
      in_ready_r <= 1'b1;
      cfg_busy_r <= 1'b0;
      cfg_done_r <= 1'b0;
      q_reg      <= Q_DEFAULT;
      mu_reg     <= MU_DEFAULT;
      shadow_q   <= Q_DEFAULT;
      shadow_mu  <= MU_DEFAULT;
    end else begin
      cfg_done_r <= 1'b0;
      case (state)
        S_RUN: begin
          if (bus.cfg_req) begin
            shadow_q   <= bus.cfg_q;
            shadow_mu  <= bus.cfg_mu;
            state      <= S_DRAIN;
            in_ready_r <= 1'b0;
            cfg_busy_r <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_done) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          q_reg      <= shadow_q;
          mu_reg     <= shadow_mu;
          state      <= S_RUN;
          in_ready_r <= 1'b1;
          cfg_busy_r <= 1'b0;
          cfg_done_r <= 1'b1;
        end
        default: begin
          state      <= S_RUN;
          in_ready_r <= 1'b1;
          cfg_busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = v_pipe[LAT-1];
  assign bus.out_data  = res_r;
  assign bus.out_tag   = tag_pipe[LAT-1];
  assign bus.out_err   = err_pipe[LAT-1];
  assign bus.cfg_busy  = cfg_busy_r;
  assign bus.cfg_done  = cfg_done_r;

endmodule

// File: tb/tb_barrett_modmul_pipe.sv
// tb/tb_barrett_modmul_pipe.sv - self-checking bench for barrett_modmul_pipe
module tb_barrett_modmul_pipe;

  localparam logic [63:0] QD  = 64'd18434813901432784897;
  localparam logic [64:0] MUD = 65'd18458681966650671896;
  localparam logic [63:0] QN  = 64'd18446744073709551557;
  localparam logic [64:0] MUN = 65'd18446744073709551675;
  localparam logic [63:0] P63 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] P32 = 64'h0000_0001_0000_0000;
  localparam logic [63:0] R64_QD = 64'd11930172276766719;
`ifdef MODMUL_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [7:0]  tag;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  tag;
    logic        err;
    bit          chk_data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  barrett_modmul_pipe_if #(.W(64), .TAG_W(8)) bus ();

  barrett_modmul_pipe #(.W(64), .MUL_STAGES(2), .TAG_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc_cnt = 0;
  int   done_cnt = 0;
  int   vcount = 0;
  int   first_cyc = 0;
  int   last_cyc = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic logic [63:0] ref_mod(input logic [63:0] a, input logic [63:0] b, input logic [63:0] q);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
    return 64'(p % {64'd0, q});
  endfunction

  // Output monitor: every out_valid is matched against the next expected result
  always @(posedge clk) begin
    #1;
    cyc_cnt++;
    if (bus.cfg_done) done_cnt++;
    if (bus.out_valid) begin
      vcount++;
      if (vcount == 1) first_cyc = cyc_cnt;
      last_cyc = cyc_cnt;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: actual tag %0h data %0d, required no output", bus.out_tag, bus.out_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_tag", 64'(bus.out_tag), 64'(mon_e.tag));
        chk("out_err", 64'(bus.out_err), 64'(mon_e.err));
        if (mon_e.chk_data) chk("out_data", bus.out_data, mon_e.data);
      end
    end
  end

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [7:0] tag,
                      input logic [63:0] d, input logic e, input bit cd);
    int n = 0;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: actual in_ready 0 after %0d cycles, required 1", n);
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back('{data: d, tag: tag, err: e, chk_data: cd});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_outstanding", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic reconfig_idle(input logic [63:0] q, input logic [64:0] mu);
    int n = 0;
    bus.cfg_req = 1'b1;
    bus.cfg_q   = q;
    bus.cfg_mu  = mu;
    @(posedge clk); #1;
    bus.cfg_req = 1'b0;
    while (!bus.in_ready && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    chk("idle_stall_cycles", 64'(n), 64'd2);
    chk("idle_cfg_done", 64'(bus.cfg_done), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int done0;
    int vsave;
    logic [63:0] ra;
    logic [63:0] rb;

    vecs[0] = '{a: 64'd2,     b: 64'd3,      tag: 8'h01, exp: 64'd6};
    vecs[1] = '{a: QD - 1,    b: QD - 1,     tag: 8'h02, exp: 64'd1};
    vecs[2] = '{a: 64'd0,     b: QD - 1,     tag: 8'h03, exp: 64'd0};
    vecs[3] = '{a: QD - 1,    b: 64'd2,      tag: 8'h04, exp: QD - 2};
    vecs[4] = '{a: QD - 1,    b: QD - 2,     tag: 8'h05, exp: 64'd2};
    vecs[5] = '{a: P63,       b: 64'd2,      tag: 8'h06, exp: R64_QD};
    vecs[6] = '{a: P32,       b: P32,        tag: 8'h07, exp: R64_QD};
    vecs[7] = '{a: 64'd1,     b: QD - 1,     tag: 8'h08, exp: QD - 1};
    vecs[8] = '{a: 64'd12345, b: 64'd67890,  tag: 8'h09, exp: 64'd838102050};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_tag = '0;
    bus.cfg_req = 1'b0;
    bus.cfg_q = '0;
    bus.cfg_mu = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    chk("rst_out_err", 64'(bus.out_err), 64'd0);
    chk("rst_cfg_busy", 64'(bus.cfg_busy), 64'd0);
    chk("rst_cfg_done", 64'(bus.cfg_done), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // First result latency: 2*3 with tag 0x11
    send(64'd2, 64'd3, 8'h11, 64'd6, 1'b0, 1'b1);
    n = 1;
    while (!bus.out_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), 64'd9);
    wait_idle();

    // Directed table, issued back to back
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp, 1'b0, 1'b1);
    end
    wait_idle();

    // 32 back-to-back random ops against a long-division reference
    vcount = 0;
    for (int i = 0; i < 32; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      ra = ra % QD;
      rb = rb % QD;
      send(ra, rb, 8'(i), ref_mod(ra, rb, QD), 1'b0, 1'b1);
    end
    wait_idle();
    chk("burst_count", 64'(vcount), 64'd32);
    chk("burst_span", 64'(last_cyc - first_cyc), 64'd31);

    // Reconfiguration under load: old ops keep the old modulus
    done0 = done_cnt;
    send(P63, 64'd2, 8'h40, R64_QD, 1'b0, 1'b1);
    send(QD - 1, QD - 1, 8'h41, 64'd1, 1'b0, 1'b1);
    send(64'd12345, 64'd67890, 8'h42, 64'd838102050, 1'b0, 1'b1);
    bus.cfg_req = 1'b1;
    bus.cfg_q   = QN;
    bus.cfg_mu  = MUN;
    send(QD - 1, 64'd2, 8'h43, QD - 2, 1'b0, 1'b1);
    bus.cfg_req = 1'b0;
    chk("load_in_ready_low", 64'(bus.in_ready), 64'd0);
    chk("load_cfg_busy", 64'(bus.cfg_busy), 64'd1);
    bus.cfg_req = 1'b1;
    bus.cfg_q   = 64'd12345;
    bus.cfg_mu  = 65'd1;
    @(posedge clk); #1;
    bus.cfg_req = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("load_done_with_ready", 64'(bus.cfg_done), 64'd1);
    chk("load_drained_first", 64'(exp_q.size()), 64'd0);
    chk("load_busy_cleared", 64'(bus.cfg_busy), 64'd0);
    @(posedge clk); #1;
    chk("load_done_one_cycle", 64'(bus.cfg_done), 64'd0);
    send(QN - 1, QN - 1, 8'h44, 64'd1, 1'b0, 1'b1);
    send(P63, 64'd2, 8'h45, 64'd59, 1'b0, 1'b1);
    wait_idle();
    chk("load_done_pulses", 64'(done_cnt - done0), 64'd1);

    // Idle reload back to the default modulus
    reconfig_idle(QD, MUD);
    send(P63, 64'd2, 8'h50, R64_QD, 1'b0, 1'b1);
    wait_idle();

    // Reset with ops in flight and a reload draining
    reconfig_idle(QN, MUN);
    for (int i = 0; i < 4; i++) begin
      send(64'd7, 64'd9, 8'(8'h58 + i), 64'd63, 1'b0, 1'b1);
    end
    bus.cfg_req = 1'b1;
    bus.cfg_q   = QN;
    bus.cfg_mu  = MUN;
    send(64'd7, 64'd9, 8'h5c, 64'd63, 1'b0, 1'b1);
    bus.cfg_req = 1'b0;
    chk("rst_mid_drain_busy", 64'(bus.cfg_busy), 64'd1);
    rst = 1'b1;
    exp_q.delete();
    vsave = vcount;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("post_rst_cfg_busy", 64'(bus.cfg_busy), 64'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_no_output", 64'(vcount - vsave), 64'd0);
    send(P63, 64'd2, 8'h60, R64_QD, 1'b0, 1'b1);
    send(64'd2, 64'd3, 8'h61, 64'd6, 1'b0, 1'b1);
    wait_idle();

    // Out-of-range operands: flagged and zeroed only when range checking is built
    send(QD, 64'd1, 8'h70, 64'd0, RC, RC);
    send(64'd1, QD - 1, 8'h71, QD - 1, 1'b0, 1'b1);
    send(64'd5, QD, 8'h72, 64'd0, RC, RC);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
